// File: rtl/axi_pkg.sv
// Shared AXI4 constants, AR attribute widths and arbiter state encoding.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned PROT_WIDTH   = 3;
  localparam int unsigned REGION_WIDTH = 4;
  localparam int unsigned LEN_WIDTH    = 8;
  localparam int unsigned SIZE_WIDTH   = 3;
  localparam int unsigned BURST_WIDTH  = 2;
  localparam int unsigned LOCK_WIDTH   = 1;
  localparam int unsigned CACHE_WIDTH  = 4;
  localparam int unsigned QOS_WIDTH    = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first eligible index after last_i, with wrap.
module rr_arb_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   mask_i,
  input  logic [IDX_WIDTH-1:0] last_i,
  output logic [IDX_WIDTH-1:0] pick_o,
  output logic                 any_valid_o
);

  logic [NUM_REQ-1:0]   eligible;
  logic                 hi_found;
  logic                 lo_found;
  logic [IDX_WIDTH-1:0] hi_idx;
  logic [IDX_WIDTH-1:0] lo_idx;

  assign eligible = req_i & ~mask_i;

  // Indices above last_i win over the wrapped-around lower part.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (eligible[k]) begin
        if (IDX_WIDTH'(k) > last_i) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDX_WIDTH'(k);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_WIDTH'(k);
        end
      end
    end
  end

  assign pick_o      = hi_found ? hi_idx : lo_idx;
  assign any_valid_o = |eligible;

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin AR channel arbiter: NUM_REQ requesters onto one AXI4 AR master port,
// prefixing the forwarded ARID with the granted requester index.
module axi_ar_rr_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned ID_WIDTH      = 16,
  parameter int unsigned USER_WIDTH    = 10,
  parameter int unsigned IDX_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                slave_valid_i,
  output logic [NUM_REQ-1:0]                slave_ready_o,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  slave_addr_i,
  input  logic [NUM_REQ*PROT_WIDTH-1:0]     slave_prot_i,
  input  logic [NUM_REQ*REGION_WIDTH-1:0]   slave_region_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      slave_len_i,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]     slave_size_i,
  input  logic [NUM_REQ*BURST_WIDTH-1:0]    slave_burst_i,
  input  logic [NUM_REQ*LOCK_WIDTH-1:0]     slave_lock_i,
  input  logic [NUM_REQ*CACHE_WIDTH-1:0]    slave_cache_i,
  input  logic [NUM_REQ*QOS_WIDTH-1:0]      slave_qos_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0]       slave_id_i,
  input  logic [NUM_REQ*USER_WIDTH-1:0]     slave_user_i,
  output logic                              master_valid_o,
  input  logic                              master_ready_i,
  output logic [ADDRESS_WIDTH-1:0]          master_addr_o,
  output logic [PROT_WIDTH-1:0]             master_prot_o,
  output logic [REGION_WIDTH-1:0]           master_region_o,
  output logic [LEN_WIDTH-1:0]              master_len_o,
  output logic [SIZE_WIDTH-1:0]             master_size_o,
  output logic [BURST_WIDTH-1:0]            master_burst_o,
  output logic [LOCK_WIDTH-1:0]             master_lock_o,
  output logic [CACHE_WIDTH-1:0]            master_cache_o,
  output logic [QOS_WIDTH-1:0]              master_qos_o,
  output logic [IDX_WIDTH+ID_WIDTH-1:0]     master_id_o,
  output logic [USER_WIDTH-1:0]             master_user_o,
  output logic [IDX_WIDTH-1:0]              grant_o
);

  arb_state_e           state_q;
  logic [IDX_WIDTH-1:0] grant_q;
  logic [IDX_WIDTH-1:0] last_q;

  logic [NUM_REQ-1:0]   served_oh;
  logic [NUM_REQ-1:0]   pick_mask;
  logic                 others_pending;
  logic [IDX_WIDTH-1:0] pick;
  logic                 any_valid;
  logic                 sel_valid;
  logic [ID_WIDTH-1:0]  sel_id;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      served_oh[k] = (grant_q == IDX_WIDTH'(k));
    end
  end

  // The served requester only drops out of the race while someone else is waiting.
  assign others_pending = |(slave_valid_i & ~served_oh);
  assign pick_mask      = (state_q == ARB_GRANT && others_pending) ? served_oh : '0;

  rr_arb_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req_i       (slave_valid_i),
    .mask_i      (pick_mask),
    .last_i      (last_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  // Payload mux; defaults to requester 0 so the bus is defined in reset and IDLE.
  always_comb begin
    sel_valid       = slave_valid_i[0];
    master_addr_o   = slave_addr_i[0 +: ADDRESS_WIDTH];
    master_prot_o   = slave_prot_i[0 +: PROT_WIDTH];
    master_region_o = slave_region_i[0 +: REGION_WIDTH];
    master_len_o    = slave_len_i[0 +: LEN_WIDTH];
    master_size_o   = slave_size_i[0 +: SIZE_WIDTH];
    master_burst_o  = slave_burst_i[0 +: BURST_WIDTH];
    master_lock_o   = slave_lock_i[0 +: LOCK_WIDTH];
    master_cache_o  = slave_cache_i[0 +: CACHE_WIDTH];
    master_qos_o    = slave_qos_i[0 +: QOS_WIDTH];
    sel_id          = slave_id_i[0 +: ID_WIDTH];
    master_user_o   = slave_user_i[0 +: USER_WIDTH];
    for (int k = 1; k < NUM_REQ; k++) begin
      if (grant_q == IDX_WIDTH'(k)) begin
        sel_valid       = slave_valid_i[k];
        master_addr_o   = slave_addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        master_prot_o   = slave_prot_i[k*PROT_WIDTH +: PROT_WIDTH];
        master_region_o = slave_region_i[k*REGION_WIDTH +: REGION_WIDTH];
        master_len_o    = slave_len_i[k*LEN_WIDTH +: LEN_WIDTH];
        master_size_o   = slave_size_i[k*SIZE_WIDTH +: SIZE_WIDTH];
        master_burst_o  = slave_burst_i[k*BURST_WIDTH +: BURST_WIDTH];
        master_lock_o   = slave_lock_i[k*LOCK_WIDTH +: LOCK_WIDTH];
        master_cache_o  = slave_cache_i[k*CACHE_WIDTH +: CACHE_WIDTH];
        master_qos_o    = slave_qos_i[k*QOS_WIDTH +: QOS_WIDTH];
        sel_id          = slave_id_i[k*ID_WIDTH +: ID_WIDTH];
        master_user_o   = slave_user_i[k*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign master_id_o    = {grant_q, sel_id};
  assign master_valid_o = (state_q == ARB_GRANT) && sel_valid;
  // Handshake: a transfer happens on a cycle where master_valid_o & master_ready_i;
  // the granted slave sees ARREADY only in that cycle, all other slaves see 0.
  assign slave_ready_o  = (master_valid_o && master_ready_i) ? served_oh : '0;
  assign grant_o        = grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_q <= pick;
            last_q  <= pick;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!sel_valid) begin
            // Granted requester withdrew: nothing transferred, keep last_q.
            state_q <= ARB_IDLE;
          end else if (master_ready_i) begin
            if (any_valid) begin
              grant_q <= pick;
              last_q  <= pick;
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Directed self-checking bench for axi_ar_rr_arbiter (4 requesters).
module tb_axi_ar_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int UW = 10;
  localparam int XW = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   s_valid;
  logic [NR-1:0]   s_ready;
  logic [NR*AW-1:0] s_addr;
  logic [NR*3-1:0] s_prot;
  logic [NR*4-1:0] s_region;
  logic [NR*8-1:0] s_len;
  logic [NR*3-1:0] s_size;
  logic [NR*2-1:0] s_burst;
  logic [NR*1-1:0] s_lock;
  logic [NR*4-1:0] s_cache;
  logic [NR*4-1:0] s_qos;
  logic [NR*IW-1:0] s_id;
  logic [NR*UW-1:0] s_user;
  logic            m_valid;
  logic            m_ready;
  logic [AW-1:0]   m_addr;
  logic [2:0]      m_prot;
  logic [3:0]      m_region;
  logic [7:0]      m_len;
  logic [2:0]      m_size;
  logic [1:0]      m_burst;
  logic [0:0]      m_lock;
  logic [3:0]      m_cache;
  logic [3:0]      m_qos;
  logic [XW+IW-1:0] m_id;
  logic [UW-1:0]   m_user;
  logic [XW-1:0]   grant;

  int errors = 0;
  int checks = 0;

  axi_ar_rr_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .slave_valid_i   (s_valid),
    .slave_ready_o   (s_ready),
    .slave_addr_i    (s_addr),
    .slave_prot_i    (s_prot),
    .slave_region_i  (s_region),
    .slave_len_i     (s_len),
    .slave_size_i    (s_size),
    .slave_burst_i   (s_burst),
    .slave_lock_i    (s_lock),
    .slave_cache_i   (s_cache),
    .slave_qos_i     (s_qos),
    .slave_id_i      (s_id),
    .slave_user_i    (s_user),
    .master_valid_o  (m_valid),
    .master_ready_i  (m_ready),
    .master_addr_o   (m_addr),
    .master_prot_o   (m_prot),
    .master_region_o (m_region),
    .master_len_o    (m_len),
    .master_size_o   (m_size),
    .master_burst_o  (m_burst),
    .master_lock_o   (m_lock),
    .master_cache_o  (m_cache),
    .master_qos_o    (m_qos),
    .master_id_o     (m_id),
    .master_user_o   (m_user),
    .grant_o         (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_all();
    s_valid = '0; s_addr = '0; s_prot = '0; s_region = '0; s_len = '0;
    s_size = '0; s_burst = '0; s_lock = '0; s_cache = '0; s_qos = '0;
    s_id = '0; s_user = '0;
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [IW-1:0] idv);
    s_valid[k]          = v;
    s_addr[k*AW +: AW]  = a;
    s_id[k*IW +: IW]    = idv;
    s_len[k*8 +: 8]     = 8'(k + 1);
    s_burst[k*2 +: 2]   = 2'b01;
    s_user[k*UW +: UW]  = UW'(k * 3 + 1);
  endtask

  // Reset released on a falling edge; DUT is then in IDLE with last=3.
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_all();
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    m_ready = 1'b1;
    s_addr[31:0] = 32'h1234_5678;
    s_valid = 4'b1111;
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_sready got=%b exp=0000", s_ready); end
    checks++; if (m_addr !== 32'h1234_5678) begin errors++; $display("FAIL reset_addr got=%h exp=12345678", m_addr); end
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 4'b0000 || grant !== 2'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d mv=%b sr=%b grant=%0d exp mv=0 sr=0000 grant=0", i, m_valid, s_ready, grant);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    set_req(2, 1'b1, 32'h8000_1000, 16'h00A5);
    m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", m_valid); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_mvalid got=%b exp=1", m_valid); end
    checks++; if (m_addr !== 32'h8000_1000) begin errors++; $display("FAIL single_addr got=%h exp=80001000", m_addr); end
    checks++; if (m_id !== 18'h200A5) begin errors++; $display("FAIL single_id got=%h exp=200a5", m_id); end
    checks++; if (m_len !== 8'd3) begin errors++; $display("FAIL single_len got=%0d exp=3", m_len); end
    checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL single_sready got=%b exp=0100", s_ready); end
    s_valid[2] = 1'b0;
    #1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL single_sready_after got=%b exp=0000", s_ready); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin errors++; $display("FAIL single_idle mv=%b sr=%b exp 0/0000", m_valid, s_ready); end
    clear_all();
    m_ready = 1'b0;
  endtask

  task automatic test_all_valid();
    logic [XW-1:0] eg;
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 32'hA000_0000 + 32'(k), 16'(16'h0100 + k));
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      eg = XW'(i % 4);
      @(negedge clk); #1;
      checks++;
      if (grant !== eg || m_valid !== 1'b1 || s_ready !== (4'b0001 << eg) || m_id[XW+IW-1:IW] !== eg) begin
        errors++;
        $display("FAIL rr_cycle%0d grant=%0d mv=%b sr=%b idx=%0d exp grant=%0d mv=1", i, grant, m_valid, s_ready, m_id[XW+IW-1:IW], eg);
      end
    end
    clear_all();
    m_ready = 1'b0;
  endtask

  task automatic test_hold();
    apply_reset();
    @(negedge clk);
    set_req(1, 1'b1, 32'h1111_0000, 16'h0011);
    set_req(3, 1'b1, 32'h3333_0000, 16'h0033);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (grant !== 2'd1 || m_valid !== 1'b1 || m_addr !== 32'h1111_0000 || s_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold_cycle%0d grant=%0d mv=%b addr=%h sr=%b exp 1/1/11110000/0000", i, grant, m_valid, m_addr, s_ready);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL hold_accept got=%b exp=0010", s_ready); end
    @(negedge clk);
    s_valid[1] = 1'b0;
    #1;
    checks++;
    if (grant !== 2'd3 || m_addr !== 32'h3333_0000 || m_id !== 18'h30033 || s_ready !== 4'b1000) begin
      errors++;
      $display("FAIL hold_next grant=%0d addr=%h id=%h sr=%b exp 3/33330000/30033/1000", grant, m_addr, m_id, s_ready);
    end
    clear_all();
    m_ready = 1'b0;
  endtask

  task automatic test_drop();
    apply_reset();
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0400, 16'h0001);
    m_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'd0 || m_valid !== 1'b1) begin errors++; $display("FAIL drop_grant grant=%0d mv=%b exp 0/1", grant, m_valid); end
    s_valid[0] = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin errors++; $display("FAIL drop_noready mv=%b sr=%b exp 0/0000", m_valid, s_ready); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drop_idle mv=%b exp=0", m_valid); end
    set_req(0, 1'b1, 32'h0000_0400, 16'h0001);
    set_req(1, 1'b1, 32'h0000_0800, 16'h0002);
    @(negedge clk); #1;
    checks++; if (grant !== 2'd1 || m_valid !== 1'b1) begin errors++; $display("FAIL drop_next_pick grant=%0d mv=%b exp 1/1", grant, m_valid); end
    clear_all();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    set_req(2, 1'b1, 32'h0000_2000, 16'h0002);
    m_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'd2 || m_valid !== 1'b1) begin errors++; $display("FAIL mid_grant grant=%0d mv=%b exp 2/1", grant, m_valid); end
    set_req(0, 1'b1, 32'h0000_0000, 16'h0000);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || grant !== 2'd0 || s_ready !== 4'b0000) begin errors++; $display("FAIL mid_async mv=%b grant=%0d sr=%b exp 0/0/0000", m_valid, grant, s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'd0 || m_valid !== 1'b1) begin errors++; $display("FAIL mid_after grant=%0d mv=%b exp 0/1", grant, m_valid); end
    clear_all();
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b0;
    clear_all();
    test_reset();
    test_single();
    test_all_valid();
    test_hold();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
